// File: rtl/proc_run_ctrl.sv
// -----------------------------------------------------------------------------
// proc_run_ctrl
//   Sequences a single-cycle processor core through one program run. It holds
//   the core in reset while presenting the entry PC, releases it, and watches
//   currentpc until it reaches the stop address. At that point it captures
//   MemtoRegOut, compares it against the expected value and raises pass/fail.
//   A watchdog ends runs that never reach the stop address.
//
// Ports
//   CLK          in   1      clock, rising edge
//   reset        in   1      synchronous, active-high
//   start        in   1      request a new run (ignored while busy)
//   start_pc     in   WIDTH  program entry address, latched on accepted start
//   stop_pc      in   WIDTH  stop address, latched on accepted start
//   expected     in   WIDTH  expected MemtoRegOut, latched on accepted start
//   currentpc    in   WIDTH  core program counter
//   memtoreg     in   WIDTH  core MemtoRegOut
//   cpu_resetl   out  1      active-low reset to the core
//   cpu_startpc  out  WIDTH  entry address to the core
//   busy         out  1      run in progress (hold or run phase)
//   done         out  1      run finished (stop hit or watchdog), held
//   pass         out  1      captured result matched expected
//   timeout      out  1      watchdog expired
//   cycles       out  CNT_W  run cycles elapsed, including the final one
//   result       out  WIDTH  captured memtoreg
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module proc_run_ctrl #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned WDOG_LIMIT  = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] start_pc,
  input  logic [WIDTH-1:0] stop_pc,
  input  logic [WIDTH-1:0] expected,
  input  logic [WIDTH-1:0] currentpc,
  input  logic [WIDTH-1:0] memtoreg,
  output logic             cpu_resetl,
  output logic [WIDTH-1:0] cpu_startpc,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  // Hold counter value seen on the edge that releases the core.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1'b1);
  localparam logic [CNT_W-1:0]  WDOG_LAST = CNT_W'(WDOG_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  state_t             state_r,       state_s;
  logic [HOLD_W-1:0]  hold_cnt_r,    hold_cnt_s;
  logic [WIDTH-1:0]   stop_q_r,      stop_q_s;
  logic [WIDTH-1:0]   expected_q_r,  expected_q_s;
  logic [WIDTH-1:0]   startpc_r,     startpc_s;
  logic               cpu_resetl_r,  cpu_resetl_s;
  logic               busy_r,        busy_s;
  logic               done_r,        done_s;
  logic               pass_r,        pass_s;
  logic               timeout_r,     timeout_s;
  logic [CNT_W-1:0]   cycles_r,      cycles_s;
  logic [WIDTH-1:0]   result_r,      result_s;
  logic [CNT_W-1:0]   cycles_inc_s;

  // Next-state and next-output decode; every register holds unless changed.
  always_comb begin
    state_s      = state_r;
    hold_cnt_s   = hold_cnt_r;
    stop_q_s     = stop_q_r;
    expected_q_s = expected_q_r;
    startpc_s    = startpc_r;
    cpu_resetl_s = cpu_resetl_r;
    busy_s       = busy_r;
    done_s       = done_r;
    pass_s       = pass_r;
    timeout_s    = timeout_r;
    cycles_s     = cycles_r;
    result_s     = result_r;
    cycles_inc_s = cycles_r + CNT_ONE;

    case (state_r)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        cpu_resetl_s = 1'b0;
        if (start) begin
          startpc_s    = start_pc;
          stop_q_s     = stop_pc;
          expected_q_s = expected;
          done_s       = 1'b0;
          pass_s       = 1'b0;
          timeout_s    = 1'b0;
          result_s     = {WIDTH{1'b0}};
          cycles_s     = {CNT_W{1'b0}};
          hold_cnt_s   = {HOLD_W{1'b0}};
          busy_s       = 1'b1;
          state_s      = ST_HOLD;
        end else begin
          state_s = state_r;
        end
      end

      ST_HOLD: begin
        // Core stays in reset for HOLD_CYCLES edges after the start edge.
        if (hold_cnt_r == HOLD_LAST) begin
          cpu_resetl_s = 1'b1;
          hold_cnt_s   = {HOLD_W{1'b0}};
          state_s      = ST_RUN;
        end else begin
          cpu_resetl_s = 1'b0;
          hold_cnt_s   = hold_cnt_r + HOLD_ONE;
        end
      end

      ST_RUN: begin
        cycles_s = cycles_inc_s;
        // Stop match is checked first so it wins over the watchdog.
        if (currentpc >= stop_q_r) begin
          result_s     = memtoreg;
          pass_s       = (memtoreg == expected_q_r);
          done_s       = 1'b1;
          busy_s       = 1'b0;
          cpu_resetl_s = 1'b0;
          state_s      = ST_DONE;
        end else if (cycles_inc_s == WDOG_LAST) begin
          timeout_s    = 1'b1;
          done_s       = 1'b1;
          pass_s       = 1'b0;
          busy_s       = 1'b0;
          cpu_resetl_s = 1'b0;
          state_s      = ST_TIMEOUT;
        end else begin
          state_s = ST_RUN;
        end
      end

      default: begin
        // Unreachable encoding: park the core in reset and go idle.
        cpu_resetl_s = 1'b0;
        busy_s       = 1'b0;
        state_s      = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      hold_cnt_r   <= {HOLD_W{1'b0}};
      stop_q_r     <= {WIDTH{1'b0}};
      expected_q_r <= {WIDTH{1'b0}};
      startpc_r    <= {WIDTH{1'b0}};
      cpu_resetl_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      timeout_r    <= 1'b0;
      cycles_r     <= {CNT_W{1'b0}};
      result_r     <= {WIDTH{1'b0}};
    end else begin
      state_r      <= state_s;
      hold_cnt_r   <= hold_cnt_s;
      stop_q_r     <= stop_q_s;
      expected_q_r <= expected_q_s;
      startpc_r    <= startpc_s;
      cpu_resetl_r <= cpu_resetl_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      pass_r       <= pass_s;
      timeout_r    <= timeout_s;
      cycles_r     <= cycles_s;
      result_r     <= result_s;
    end
  end

  assign cpu_resetl  = cpu_resetl_r;
  assign cpu_startpc = startpc_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign pass        = pass_r;
  assign timeout     = timeout_r;
  assign cycles      = cycles_r;
  assign result      = result_r;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_proc_run_ctrl
//   Scoreboard bench for proc_run_ctrl. A simple core model advances its PC by
//   a fixed step while released; memory data is a function of the PC. Each
//   accepted start pushes the outcome predicted from the run rules; a monitor
//   pops and compares whenever done rises.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_proc_run_ctrl;

  localparam int W    = 64;
  localparam int CW   = 16;
  localparam int WDOG = 255;

  typedef struct {
    logic [63:0] result;
    logic        pass;
    logic        timeout;
    logic [15:0] cycles;
    logic [63:0] spc;
  } exp_t;

  logic          CLK;
  logic          reset;
  logic          start;
  logic [W-1:0]  start_pc, stop_pc, expected;
  logic [W-1:0]  currentpc, memtoreg;
  logic          cpu_resetl;
  logic [W-1:0]  cpu_startpc;
  logic          busy, done, pass, timeout;
  logic [CW-1:0] cycles;
  logic [W-1:0]  result;

  // environment: core and memory model knobs
  logic [63:0] core_pc;
  logic [63:0] core_step;
  bit          use_ovr;
  logic [63:0] ovr_a, ovr_d, salt;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic done_d   = 1'b0;

  proc_run_ctrl #(.WIDTH(W), .HOLD_CYCLES(2), .WDOG_LIMIT(WDOG), .CNT_W(CW)) dut (
    .CLK(CLK), .reset(reset), .start(start),
    .start_pc(start_pc), .stop_pc(stop_pc), .expected(expected),
    .currentpc(currentpc), .memtoreg(memtoreg),
    .cpu_resetl(cpu_resetl), .cpu_startpc(cpu_startpc),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .cycles(cycles), .result(result)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [63:0] mem_val(input logic [63:0] pc, input bit uo,
                                          input logic [63:0] oa, input logic [63:0] od,
                                          input logic [63:0] sl);
    if (uo) return (pc == oa) ? od : 64'd0;
    else    return {pc[31:0], ~pc[31:0]} ^ sl;
  endfunction

  // Core model: loads startpc while held in reset, then steps.
  always @(posedge CLK) begin
    if (!cpu_resetl) core_pc <= cpu_startpc;
    else             core_pc <= core_pc + core_step;
  end

  assign currentpc = core_pc;
  assign memtoreg  = mem_val(core_pc, use_ovr, ovr_a, ovr_d, salt);

  // Run k (0-based) sees pc = start + step*k; first k with pc >= stop ends it.
  function automatic exp_t model_run(input logic [63:0] spc, input logic [63:0] stp,
                                     input logic [63:0] expv);
    exp_t        e;
    logic [63:0] pc;
    e.timeout = 1'b1;
    e.cycles  = 16'(WDOG);
    e.result  = 64'd0;
    e.pass    = 1'b0;
    e.spc     = spc;
    for (int k = 0; k < WDOG; k++) begin
      pc = spc + core_step * 64'(k);
      if (pc >= stp) begin
        e.timeout = 1'b0;
        e.cycles  = 16'(k + 1);
        e.result  = mem_val(pc, use_ovr, ovr_a, ovr_d, salt);
        e.pass    = (e.result == expv);
        break;
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cpu_resetl"}, 64'(cpu_resetl), 64'd0);
    chk({tag, "_busy"},       64'(busy),       64'd0);
    chk({tag, "_done"},       64'(done),       64'd0);
    chk({tag, "_pass"},       64'(pass),       64'd0);
    chk({tag, "_timeout"},    64'(timeout),    64'd0);
    chk({tag, "_cycles"},     64'(cycles),     64'd0);
    chk({tag, "_result"},     result,          64'd0);
    chk({tag, "_startpc"},    cpu_startpc,     64'd0);
  endtask

  // Issue a start and push the predicted outcome; returns after the start edge.
  task automatic do_start(input logic [63:0] s, input logic [63:0] p, input logic [63:0] e);
    start_pc = s;
    stop_pc  = p;
    expected = e;
    start    = 1'b1;
    sb_q.push_back(model_run(s, p, e));
    @(negedge CLK);
    start = 1'b0;
    chk("start_busy",    64'(busy),   64'd1);
    chk("start_done",    64'(done),   64'd0);
    chk("start_startpc", cpu_startpc, s);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: done not seen within cycle bound", tag);
    end
  endtask

  // Monitor: compare each finished run against the scoreboard head.
  always @(negedge CLK) begin
    if (!reset && done && !done_d) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_done: got done=1, expected no pending run");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("mon_result",     result,             e.result);
        chk("mon_pass",       64'(pass),          64'(e.pass));
        chk("mon_timeout",    64'(timeout),       64'(e.timeout));
        chk("mon_cycles",     64'(cycles),        64'(e.cycles));
        chk("mon_busy",       64'(busy),          64'd0);
        chk("mon_cpu_resetl", 64'(cpu_resetl),    64'd0);
        chk("mon_startpc",    cpu_startpc,        e.spc);
      end
    end
    done_d <= done;
  end

  initial begin
    logic [63:0] s, p, e;
    exp_t        probe;

    reset = 1'b1; start = 1'b0;
    start_pc = 64'd0; stop_pc = 64'd0; expected = 64'd0;
    core_step = 64'd4; use_ovr = 1'b1; ovr_a = 64'h30; ovr_d = 64'hF; salt = 64'd0;

    // 1: reset state
    repeat (2) @(negedge CLK);
    check_zero("reset");
    reset = 1'b0;
    @(negedge CLK);

    // 2: basic run, core held low two cycles after start
    do_start(64'd0, 64'h30, 64'hF);
    chk("hold_edge1", 64'(cpu_resetl), 64'd0);
    @(negedge CLK);
    chk("hold_edge2", 64'(cpu_resetl), 64'd0);
    @(negedge CLK);
    chk("release",    64'(cpu_resetl), 64'd1);
    wait_done("basic");
    chk("basic_cycles", 64'(cycles), 64'd13);
    chk("basic_result", result,      64'hF);
    chk("basic_pass",   64'(pass),   64'd1);
    @(negedge CLK);

    // 3: mismatch
    ovr_d = 64'd0;
    do_start(64'd0, 64'h30, 64'h123456789abcdef0);
    wait_done("mismatch");
    chk("mismatch_pass",    64'(pass),    64'd0);
    chk("mismatch_timeout", 64'(timeout), 64'd0);
    @(negedge CLK);

    // 4: watchdog with pc stuck at 0x10
    core_step = 64'd0;
    do_start(64'h10, 64'h60, 64'd0);
    wait_done("watchdog");
    chk("wdog_timeout", 64'(timeout), 64'd1);
    chk("wdog_cycles",  64'(cycles),  64'd255);
    chk("wdog_pass",    64'(pass),    64'd0);
    @(negedge CLK);

    // 5a: start pulsed mid-run is ignored
    core_step = 64'd4; use_ovr = 1'b0; salt = 64'hA5A5_0000_1234_5678;
    do_start(64'd0, 64'h100, 64'd0);
    repeat (10) @(negedge CLK);
    start_pc = 64'h40; stop_pc = 64'd0; expected = 64'hDEAD; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done("ignore_start");
    @(negedge CLK);

    // 5b: reset mid-run aborts to idle with all outputs cleared
    do_start(64'h8, 64'h200, 64'd0);
    repeat (8) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    check_zero("abort");
    sb_q.delete();
    reset = 1'b0;
    @(negedge CLK);

    // 6: stop_pc == start_pc ends on the first run cycle, then rerun
    do_start(64'd0, 64'd0, 64'd0);
    wait_done("stop_eq_start");
    chk("eq_cycles", 64'(cycles), 64'd1);
    @(negedge CLK);
    do_start(64'd0, 64'd0, 64'd1);
    wait_done("stop_eq_rerun");
    chk("rerun_cycles", 64'(cycles), 64'd1);
    @(negedge CLK);

    // randomized runs: mix of hits, stop behind start, and watchdog expiry
    for (int r = 0; r < 20; r++) begin
      core_step = 64'($urandom_range(0, 3)) * 64'd4;
      salt      = {$urandom, $urandom};
      s         = 64'($urandom_range(0, 255)) * 64'd4;
      if ($urandom_range(0, 9) == 0) p = s - 64'($urandom_range(0, 4));
      else                           p = s + 64'($urandom_range(0, 1200));
      probe = model_run(s, p, 64'd0);
      if ($urandom_range(0, 1) == 1) e = probe.result;
      else                           e = {$urandom, $urandom};
      do_start(s, p, e);
      wait_done("random_run");
      repeat ($urandom_range(1, 3)) @(negedge CLK);
    end

    repeat (3) @(negedge CLK);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
